// File: rtl/dcache_mshr_mt_pkg.sv
// Shared types and defaults for the L1 D-cache miss status holding registers.
// The entry state encoding and the line address type are used by the top, the entries and the interface.
package dcache_mshr_mt_pkg;

  localparam int L1C_MSHR_ENTRIES     = 4;
  localparam int L1C_MSHR_MAX_TARGETS = 4;
  localparam int LINE_ADDR_BITS       = 26;

  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    VALID = 2'd1,
    WAIT  = 2'd2
  } mshr_state_e;

endpackage

// File: rtl/dcache_mshr_mt_if.sv
// D1/L2C-facing signal bundle of the MSHR; the slave modport is the MSHR side.
// Latency and backpressure live in the MSHR; this file only groups the wires.
interface dcache_mshr_mt_if
  import dcache_mshr_mt_pkg::*;
#(
  parameter int ENTRIES     = L1C_MSHR_ENTRIES,
  parameter int LINE_ADDR_W = $bits(line_addr_t),
  parameter int MAX_TARGETS = L1C_MSHR_MAX_TARGETS
);
  localparam int ID_W  = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int TGT_W = $clog2(MAX_TARGETS + 1);

  logic                   clr_all_i;
  logic                   alloc_valid_i;
  logic [LINE_ADDR_W-1:0] alloc_line_addr_i;
  logic                   alloc_ready_o;
  logic [ID_W-1:0]        alloc_id_o;
  logic [LINE_ADDR_W-1:0] lookup_line_addr_i;
  logic                   lookup_hit_o;
  logic [ID_W-1:0]        lookup_id_o;
  logic                   merge_i;
  logic                   merge_ready_o;
  logic                   l2c_req_valid_o;
  logic                   l2c_req_ready_i;
  logic [LINE_ADDR_W-1:0] l2c_req_line_addr_o;
  logic [ID_W-1:0]        l2c_req_id_o;
  logic                   l2c_rsp_valid_i;
  logic [ID_W-1:0]        l2c_rsp_id_i;
  logic [LINE_ADDR_W-1:0] rsp_line_addr_o;
  logic [TGT_W-1:0]       rsp_targets_o;
  logic                   rsp_err_o;
  logic                   full_o;
  logic                   empty_o;
  logic [CNT_W-1:0]       pending_req_o;

  modport slave (
    input  clr_all_i, alloc_valid_i, alloc_line_addr_i, lookup_line_addr_i, merge_i,
           l2c_req_ready_i, l2c_rsp_valid_i, l2c_rsp_id_i,
    output alloc_ready_o, alloc_id_o, lookup_hit_o, lookup_id_o, merge_ready_o,
           l2c_req_valid_o, l2c_req_line_addr_o, l2c_req_id_o, rsp_line_addr_o,
           rsp_targets_o, rsp_err_o, full_o, empty_o, pending_req_o
  );

  modport master (
    output clr_all_i, alloc_valid_i, alloc_line_addr_i, lookup_line_addr_i, merge_i,
           l2c_req_ready_i, l2c_rsp_valid_i, l2c_rsp_id_i,
    input  alloc_ready_o, alloc_id_o, lookup_hit_o, lookup_id_o, merge_ready_o,
           l2c_req_valid_o, l2c_req_line_addr_o, l2c_req_id_o, rsp_line_addr_o,
           rsp_targets_o, rsp_err_o, full_o, empty_o, pending_req_o
  );
endinterface

// File: rtl/dcache_mshr_entry.sv
// One MSHR slot: FREE/VALID/WAIT state, line address, merged-target counter and address comparators.
// Events take effect on the next clock; flush overrides every per-entry event.
module dcache_mshr_entry
  import dcache_mshr_mt_pkg::*;
#(
  parameter int LINE_ADDR_W = 26,
  parameter int TGT_W       = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   alloc_i,
  input  logic [LINE_ADDR_W-1:0] alloc_addr_i,
  input  logic                   issue_i,
  input  logic                   merge_i,
  input  logic                   retire_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  output mshr_state_e            state_o,
  output mshr_state_e            state_nxt_o,
  output logic [LINE_ADDR_W-1:0] addr_o,
  output logic [TGT_W-1:0]       tgt_o,
  output logic                   lookup_match_o,
  output logic                   alloc_match_o
);
  mshr_state_e            state_q, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [TGT_W-1:0]       tgt_q, tgt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    case (state_q)
      FREE: if (alloc_i) begin
        state_d = VALID;
        addr_d  = alloc_addr_i;
        tgt_d   = TGT_W'(1);
      end
      VALID: if (issue_i) state_d = WAIT;
      WAIT: if (retire_i) begin
        state_d = FREE;
        tgt_d   = '0;
      end
      default: state_d = FREE;
    endcase
    // The top never asserts merge and retire together, so the increment cannot resurrect a freed slot.
    if (merge_i && state_q != FREE) tgt_d = tgt_q + TGT_W'(1);
    if (clr_i) begin
      state_d = FREE;
      tgt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FREE;
      addr_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
    end
  end

  assign state_o        = state_q;
  assign state_nxt_o    = state_d;
  assign addr_o         = addr_q;
  assign tgt_o          = tgt_q;
  assign lookup_match_o = (state_q != FREE) && (addr_q == lookup_addr_i);
  assign alloc_match_o  = (state_q != FREE) && (addr_q == alloc_addr_i);
endmodule

// File: rtl/dcache_mshr_mt.sv
// Multi-target D-cache MSHR: allocates/merges misses, issues tagged L2C requests, retires on tagged responses.
// Lookup, alloc grant and response data are combinational; the L2C request is registered and held until accepted.
module dcache_mshr_mt
  import dcache_mshr_mt_pkg::*;
#(
  parameter int ENTRIES     = L1C_MSHR_ENTRIES,
  parameter int LINE_ADDR_W = $bits(line_addr_t),
  parameter int MAX_TARGETS = L1C_MSHR_MAX_TARGETS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_mshr_mt_if.slave   bus
);
  localparam int ID_W  = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int TGT_W = $clog2(MAX_TARGETS + 1);

  mshr_state_e            ent_state [ENTRIES];
  mshr_state_e            ent_nxt   [ENTRIES];
  logic [LINE_ADDR_W-1:0] ent_addr  [ENTRIES];
  logic [TGT_W-1:0]       ent_tgt   [ENTRIES];
  logic [ENTRIES-1:0]     lookup_match, alloc_match;
  logic [ENTRIES-1:0]     free_vec, valid_vec, hit_vec, retire_vec;
  logic [ENTRIES-1:0]     alloc_vec, issue_vec, merge_vec;
  logic [ID_W-1:0]        free_id, valid_id, hit_id;
  logic                   rsp_in_wait, alloc_go, merge_go, issue_hs, merge_rdy;

  logic                   req_valid_q, req_valid_d;
  logic [ID_W-1:0]        req_id_q, req_id_d;
  logic [LINE_ADDR_W-1:0] req_addr_q, req_addr_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]       pending_q, pending_d;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    dcache_mshr_entry #(
      .LINE_ADDR_W (LINE_ADDR_W),
      .TGT_W       (TGT_W)
    ) u_entry (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clr_i          (bus.clr_all_i),
      .alloc_i        (alloc_vec[g]),
      .alloc_addr_i   (bus.alloc_line_addr_i),
      .issue_i        (issue_vec[g]),
      .merge_i        (merge_vec[g]),
      .retire_i       (retire_vec[g]),
      .lookup_addr_i  (bus.lookup_line_addr_i),
      .state_o        (ent_state[g]),
      .state_nxt_o    (ent_nxt[g]),
      .addr_o         (ent_addr[g]),
      .tgt_o          (ent_tgt[g]),
      .lookup_match_o (lookup_match[g]),
      .alloc_match_o  (alloc_match[g])
    );
  end

  always_comb begin
    free_vec    = '0;
    valid_vec   = '0;
    retire_vec  = '0;
    free_id     = '0;
    valid_id    = '0;
    hit_id      = '0;
    rsp_in_wait = bus.l2c_rsp_valid_i && (int'(bus.l2c_rsp_id_i) < ENTRIES)
                  && (ent_state[bus.l2c_rsp_id_i] == WAIT);
    if (rsp_in_wait && !bus.clr_all_i) retire_vec[bus.l2c_rsp_id_i] = 1'b1;
    // A retiring entry no longer accepts merges, so it must not report a hit.
    hit_vec = lookup_match & ~retire_vec;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_vec[i]  = (ent_state[i] == FREE);
      valid_vec[i] = (ent_state[i] == VALID);
      if (ent_state[i] == FREE)  free_id  = ID_W'(i);
      if (ent_state[i] == VALID) valid_id = ID_W'(i);
      if (hit_vec[i])            hit_id   = ID_W'(i);
    end
  end

  assign bus.full_o        = ~|free_vec;
  assign bus.empty_o       = &free_vec;
  assign bus.alloc_ready_o = ~bus.full_o && ~|alloc_match;
  assign bus.alloc_id_o    = free_id;
  assign alloc_go          = bus.alloc_valid_i && bus.alloc_ready_o;
  assign alloc_vec         = ENTRIES'(alloc_go) << free_id;

  assign bus.lookup_hit_o  = |hit_vec;
  assign bus.lookup_id_o   = hit_id;
  assign merge_rdy         = (|hit_vec) && (ent_tgt[hit_id] < TGT_W'(MAX_TARGETS));
  assign bus.merge_ready_o = merge_rdy;
  assign merge_go          = bus.merge_i && merge_rdy;
  assign merge_vec         = ENTRIES'(merge_go) << hit_id;

  assign issue_hs          = req_valid_q && bus.l2c_req_ready_i;
  assign issue_vec         = ENTRIES'(issue_hs) << req_id_q;

  always_comb begin
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_addr_d  = req_addr_q;
    if (issue_hs) begin
      req_valid_d = 1'b0;
    end else if (!req_valid_q && |valid_vec) begin
      req_valid_d = 1'b1;
      req_id_d    = valid_id;
      req_addr_d  = ent_addr[valid_id];
    end
    if (bus.clr_all_i) req_valid_d = 1'b0;

    rsp_err_d = bus.l2c_rsp_valid_i && !bus.clr_all_i && !rsp_in_wait;

    pending_d = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (ent_nxt[i] == WAIT) pending_d = pending_d + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_addr_q  <= '0;
      rsp_err_q   <= 1'b0;
      pending_q   <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_addr_q  <= req_addr_d;
      rsp_err_q   <= rsp_err_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.l2c_req_valid_o     = req_valid_q;
  assign bus.l2c_req_id_o        = req_id_q;
  assign bus.l2c_req_line_addr_o = req_addr_q;
  assign bus.rsp_line_addr_o     = ent_addr[bus.l2c_rsp_id_i];
  assign bus.rsp_targets_o       = ent_tgt[bus.l2c_rsp_id_i];
  assign bus.rsp_err_o           = rsp_err_q;
  assign bus.pending_req_o       = pending_q;
endmodule
